// File: rtl/sram_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_req_arbiter_pkg
// Brief    : Owner encoding and default sizing shared by the SRAM request arbiter.
// Revision : 1.0
// ============================================================================
package sram_req_arbiter_pkg;

    localparam int   DEPTH_DEFAULT = 2;
    localparam logic OWN_INST      = 1'b0;
    localparam logic OWN_DATA      = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sram_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_req_arbiter_if
// Brief    : SRAM-like request/response bundle; master drives the request side.
// Revision : 1.0
// ============================================================================
interface sram_req_arbiter_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface
`default_nettype wire

// File: rtl/sram_owner_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sram_owner_fifo
// Brief    : 1-bit owner FIFO tracking which port each outstanding request belongs to.
// Revision : 1.0
// ============================================================================
module sram_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_req_arbiter
// Brief    : Round-robin merge of inst/data SRAM-like ports onto one downstream port.
// Revision : 1.0
// ============================================================================
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      resetn,
    sram_req_arbiter_if.slave         inst_sram,
    sram_req_arbiter_if.slave         data_sram,
    sram_req_arbiter_if.master        dn_sram,
    output logic                      err_orphan
);

    logic w_grant;
    logic w_sel_data;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_dn_req;
    logic w_xfer;
    logic w_pop;

    logic r_lock;
    logic r_lock_owner;
    logic r_last_grant;
    logic r_err_orphan;

    // A pending un-accepted request pins the grant so the downstream bundle stays stable.
    always_comb begin
        w_grant = OWN_INST;
        if (r_lock) begin
            w_grant = r_lock_owner;
        end else if (inst_sram.req && data_sram.req) begin
            w_grant = ~r_last_grant;
        end else if (data_sram.req) begin
            w_grant = OWN_DATA;
        end
    end

    assign w_sel_data = (w_grant == OWN_DATA);
    assign w_dn_req   = (w_sel_data ? data_sram.req : inst_sram.req) & ~w_full;
    assign w_xfer     = w_dn_req & dn_sram.addr_ok;
    assign w_pop      = dn_sram.data_ok & ~w_empty;

    assign dn_sram.req   = w_dn_req;
    assign dn_sram.wr    = w_sel_data ? data_sram.wr    : inst_sram.wr;
    assign dn_sram.size  = w_sel_data ? data_sram.size  : inst_sram.size;
    assign dn_sram.wstrb = w_sel_data ? data_sram.wstrb : inst_sram.wstrb;
    assign dn_sram.addr  = w_sel_data ? data_sram.addr  : inst_sram.addr;
    assign dn_sram.wdata = w_sel_data ? data_sram.wdata : inst_sram.wdata;

    assign inst_sram.addr_ok = w_xfer & ~w_sel_data;
    assign data_sram.addr_ok = w_xfer & w_sel_data;
    assign inst_sram.data_ok = w_pop & (w_head == OWN_INST);
    assign data_sram.data_ok = w_pop & (w_head == OWN_DATA);
    assign inst_sram.rdata   = dn_sram.rdata;
    assign data_sram.rdata   = dn_sram.rdata;
    assign err_orphan        = r_err_orphan;

    sram_owner_fifo #(
        .DEPTH (DEPTH)
    ) u_owner_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_xfer),
        .pop    (w_pop),
        .din    (w_grant),
        .dout   (w_head),
        .full   (w_full),
        .empty  (w_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lock       <= 1'b0;
            r_lock_owner <= OWN_INST;
            r_last_grant <= OWN_DATA;
            r_err_orphan <= 1'b0;
        end else begin
            r_lock       <= w_dn_req & ~dn_sram.addr_ok;
            r_lock_owner <= w_grant;
            if (w_xfer) begin
                r_last_grant <= w_grant;
            end
            if (dn_sram.data_ok && w_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_req_arbiter
// Brief    : Directed self-checking bench with an owner scoreboard queue.
// Revision : 1.0
// ============================================================================
module tb_sram_req_arbiter;

    logic clk = 1'b0;
    logic resetn;
    logic err_orphan;

    sram_req_arbiter_if inst_if ();
    sram_req_arbiter_if data_if ();
    sram_req_arbiter_if dn_if ();

    sram_req_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .inst_sram  (inst_if),
        .data_sram  (data_if),
        .dn_sram    (dn_if),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          exp_orphan;
    bit          own_q[$];
    logic [31:0] ia;
    logic [31:0] da;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        inst_if.req   = 1'b0; inst_if.wr   = 1'b0; inst_if.size  = 2'd0;
        inst_if.wstrb = 4'h0; inst_if.addr = '0;   inst_if.wdata = '0;
        data_if.req   = 1'b0; data_if.wr   = 1'b0; data_if.size  = 2'd0;
        data_if.wstrb = 4'h0; data_if.addr = '0;   data_if.wdata = '0;
        dn_if.addr_ok = 1'b0; dn_if.data_ok = 1'b0; dn_if.rdata = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive_idle();
        own_q.delete();
        exp_orphan = 1'b0;
        #2;
        chk1("rst_err_orphan", err_orphan, 1'b0);
        chk1("rst_dn_req", dn_if.req, 1'b0);
        chk32("rst_dn_addr", dn_if.addr, 32'h0);
        chk1("rst_inst_addr_ok", inst_if.addr_ok, 1'b0);
        chk1("rst_data_data_ok", data_if.data_ok, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    // g: expected downstream grant this cycle (0 none, 1 inst, 2 data)
    task automatic cyc(input bit ir, input bit dr, input bit aok, input bit dok,
                       input logic [31:0] rd, input int g);
        bit o;
        bit orphan_now;
        inst_if.req   = ir;    inst_if.addr  = ia;    inst_if.wr    = 1'b0;
        inst_if.size  = 2'd2;  inst_if.wstrb = 4'h0;  inst_if.wdata = 32'h0;
        data_if.req   = dr;    data_if.addr  = da;    data_if.wr    = 1'b1;
        data_if.size  = 2'd2;  data_if.wstrb = 4'hF;  data_if.wdata = da ^ 32'h5A5A_5A5A;
        dn_if.addr_ok = aok;   dn_if.data_ok = dok;   dn_if.rdata   = rd;
        #2;
        chk1("dn_req", dn_if.req, g != 0);
        if (g == 1) begin
            chk32("dn_addr_inst", dn_if.addr, ia);
            chk1("dn_wr_inst", dn_if.wr, 1'b0);
        end
        if (g == 2) begin
            chk32("dn_addr_data", dn_if.addr, da);
            chk32("dn_wdata_data", dn_if.wdata, da ^ 32'h5A5A_5A5A);
        end
        chk1("inst_addr_ok", inst_if.addr_ok, (g == 1) && aok);
        chk1("data_addr_ok", data_if.addr_ok, (g == 2) && aok);
        orphan_now = 1'b0;
        if (dok && own_q.size() > 0) begin
            o = own_q.pop_front();
            chk1("inst_data_ok", inst_if.data_ok, o == 1'b0);
            chk1("data_data_ok", data_if.data_ok, o == 1'b1);
            chk32("rdata", o ? data_if.rdata : inst_if.rdata, rd);
        end else begin
            chk1("inst_data_ok_quiet", inst_if.data_ok, 1'b0);
            chk1("data_data_ok_quiet", data_if.data_ok, 1'b0);
            orphan_now = dok;
        end
        chk1("err_orphan", err_orphan, exp_orphan);
        if (g != 0 && aok) own_q.push_back(g == 2);
        @(posedge clk); #1;
        if (orphan_now) exp_orphan = 1'b1;
    endtask

    initial begin
        ia = 32'h0;
        da = 32'h0;
        do_reset();

        // single inst read, completion two cycles after acceptance
        ia = 32'h0000_1000;
        cyc(1, 0, 1, 0, 32'h0, 1);
        cyc(0, 0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        cyc(0, 0, 0, 0, 32'h0, 0);

        // both ports streaming: grants alternate starting with inst
        do_reset();
        ia = 32'h0000_2000;
        da = 32'h0000_3000;
        cyc(1, 1, 1, 0, 32'h0, 1);
        cyc(1, 1, 1, 1, 32'h1111_0001, 2);
        cyc(1, 1, 1, 1, 32'h1111_0002, 1);
        cyc(1, 1, 1, 1, 32'h1111_0003, 2);
        cyc(0, 0, 0, 1, 32'h1111_0004, 0);

        // FIFO full holds the third inst request, including the pop cycle
        ia = 32'h0000_4000;
        cyc(1, 0, 1, 0, 32'h0, 1);
        cyc(1, 0, 1, 0, 32'h0, 1);
        cyc(1, 0, 1, 0, 32'h0, 0);
        cyc(1, 0, 1, 0, 32'h0, 0);
        cyc(1, 0, 1, 1, 32'h2222_0001, 0);
        cyc(1, 0, 1, 0, 32'h0, 1);
        cyc(0, 0, 0, 1, 32'h2222_0002, 0);
        cyc(0, 0, 0, 1, 32'h2222_0003, 0);

        // grant lock: inst stalled three cycles while data requests
        ia = 32'h0000_5000;
        da = 32'h0000_6000;
        cyc(1, 0, 0, 0, 32'h0, 1);
        cyc(1, 1, 0, 0, 32'h0, 1);
        cyc(1, 1, 0, 0, 32'h0, 1);
        cyc(1, 1, 1, 0, 32'h0, 1);
        cyc(1, 1, 1, 0, 32'h0, 2);
        cyc(0, 0, 0, 1, 32'h3333_0001, 0);
        cyc(0, 0, 0, 1, 32'h3333_0002, 0);

        // orphan completion is dropped and the flag is sticky
        cyc(0, 0, 0, 1, 32'h4444_0001, 0);
        cyc(0, 0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 0, 32'h0, 0);

        // reset with two outstanding requests discards ownership
        ia = 32'h0000_7000;
        da = 32'h0000_8000;
        cyc(1, 0, 1, 0, 32'h0, 1);
        cyc(0, 1, 1, 0, 32'h0, 2);
        do_reset();
        cyc(0, 0, 0, 1, 32'h5555_0001, 0);
        cyc(1, 0, 1, 0, 32'h0, 1);
        cyc(0, 0, 0, 1, 32'h5555_0002, 0);
        cyc(0, 0, 0, 0, 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
